// File: rtl/dm_store_queue.sv
// Store queue between MEM and the word-addressed DM/bridge: checks sw/sh/sb for AdES,
// formats lane enables and replicated data, and drains in order over valid/ready.
module dm_store_queue #(
   parameter int          DEPTH  = 4,
   parameter logic [31:0] DM_HI  = 32'h0000_2FFF,
   parameter logic [31:0] DEV_LO = 32'h0000_7F00,
   parameter logic [31:0] DEV_HI = 32'h0000_7F1B,
   parameter logic [2:0]  CTR_SB = 3'b000,
   parameter logic [2:0]  CTR_SH = 3'b001,
   parameter logic [2:0]  CTR_SW = 3'b010
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        st_valid,
   output logic        st_ready,
   input  logic [2:0]  st_ctr,
   input  logic [31:0] st_addr,
   input  logic [31:0] st_data,
   input  logic [31:0] ld_addr,
   input  logic        ld_en,
   output logic        ld_hit,
   output logic        exc_ades,
   output logic [31:0] badvaddr,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [3:0]  mem_be,
   output logic [31:0] mem_wdata,
   input  logic        mem_ready,
   output logic        empty
);

   localparam int             PW       = $clog2(DEPTH);
   localparam logic [PW:0]    CNT_FULL = (PW+1)'(DEPTH);
   localparam logic [PW:0]    CNT_ONE  = (PW+1)'(1);
   localparam logic [PW-1:0]  PTR_ONE  = PW'(1);

   logic [PW-1:0] r_head, r_tail;
   logic [PW:0]   r_count;
   logic [29:0]   r_waddr [DEPTH];
   logic [3:0]    r_be    [DEPTH];
   logic [31:0]   r_wdata [DEPTH];
   logic          r_exc;
   logic [31:0]   r_badvaddr;

   logic        w_is_sw, w_is_sh, w_is_sb, w_legal;
   logic        w_in_dm, w_in_dev, w_fault;
   logic        w_acc, w_push, w_pop;
   logic [3:0]  w_be;
   logic [31:0] w_wdata;

   assign w_is_sw = (st_ctr == CTR_SW);
   assign w_is_sh = (st_ctr == CTR_SH);
   assign w_is_sb = (st_ctr == CTR_SB);
   assign w_legal = w_is_sw | w_is_sh | w_is_sb;

   assign w_in_dm  = (st_addr <= DM_HI);
   assign w_in_dev = (st_addr >= DEV_LO) && (st_addr <= DEV_HI);
   // The device window only takes full-word accesses.
   assign w_fault  = (w_is_sh && st_addr[0])
                   | (w_is_sw && (st_addr[1:0] != 2'b00))
                   | (!w_in_dm && !w_in_dev)
                   | ((w_is_sb || w_is_sh) && w_in_dev);

   assign st_ready = (r_count < CNT_FULL);
   assign w_acc    = st_valid && st_ready && w_legal;
   assign w_push   = w_acc && !w_fault;
   assign w_pop    = mem_we && mem_ready;

   always_comb begin
      w_be    = 4'b1111;
      w_wdata = st_data;
      if (w_is_sh) begin
         w_be    = st_addr[1] ? 4'b1100 : 4'b0011;
         w_wdata = {2{st_data[15:0]}};
      end else if (w_is_sb) begin
         w_be    = 4'b0001 << st_addr[1:0];
         w_wdata = {4{st_data[7:0]}};
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_head     <= '0;
         r_tail     <= '0;
         r_count    <= '0;
         r_exc      <= 1'b0;
         r_badvaddr <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            r_waddr[i] <= '0;
            r_be[i]    <= '0;
            r_wdata[i] <= '0;
         end
      end else begin
         r_exc <= w_acc && w_fault;
         if (w_acc && w_fault)
            r_badvaddr <= st_addr;
         if (w_push) begin
            r_waddr[r_tail] <= st_addr[31:2];
            r_be[r_tail]    <= w_be;
            r_wdata[r_tail] <= w_wdata;
            r_tail          <= r_tail + PTR_ONE;
         end
         if (w_pop)
            r_head <= r_head + PTR_ONE;
         unique case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CNT_ONE;
            2'b01:   r_count <= r_count - CNT_ONE;
            default: r_count <= r_count;
         endcase
      end
   end

   // An entry is live when its distance from head is below count; the store being
   // pushed this cycle is not yet live, the pipeline orders it against the load.
   always_comb begin
      logic [PW-1:0] v_off;
      ld_hit = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         v_off = PW'(i) - r_head;
         if (ld_en && ({1'b0, v_off} < r_count) && (r_waddr[i] == ld_addr[31:2]))
            ld_hit = 1'b1;
      end
   end

   assign mem_we    = (r_count != '0);
   assign empty     = !mem_we;
   assign mem_addr  = mem_we ? {r_waddr[r_head], 2'b00} : 32'h0;
   assign mem_be    = mem_we ? r_be[r_head] : 4'b0000;
   assign mem_wdata = mem_we ? r_wdata[r_head] : 32'h0;
   assign exc_ades  = r_exc;
   assign badvaddr  = r_badvaddr;

endmodule

// File: tb/tb_dm_store_queue.sv
// Directed bench for dm_store_queue: queue-based reference model checked every cycle,
// plus literal expectations taken from the hand-worked scenarios.
module tb_dm_store_queue;

   localparam int         DEPTH = 4;
   localparam logic [2:0] SB = 3'b000, SH = 3'b001, SW = 3'b010;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        st_valid = 1'b0;
   logic        st_ready;
   logic [2:0]  st_ctr = SW;
   logic [31:0] st_addr = '0, st_data = '0, ld_addr = '0;
   logic        ld_en = 1'b0;
   logic        ld_hit, exc_ades, mem_we, empty;
   logic [31:0] badvaddr, mem_addr, mem_wdata;
   logic [3:0]  mem_be;
   logic        mem_ready = 1'b0;

   dm_store_queue #(.DEPTH(DEPTH)) dut (
      .clk(clk), .reset_n(reset_n), .st_valid(st_valid), .st_ready(st_ready),
      .st_ctr(st_ctr), .st_addr(st_addr), .st_data(st_data), .ld_addr(ld_addr),
      .ld_en(ld_en), .ld_hit(ld_hit), .exc_ades(exc_ades), .badvaddr(badvaddr),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
      .mem_ready(mem_ready), .empty(empty)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   bit chk_en = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: a plain queue of formatted stores.
   typedef struct {
      logic [31:0] a;
      logic [3:0]  be;
      logic [31:0] d;
   } ent_t;

   ent_t        mq[$];
   logic        m_exc = 1'b0;
   logic [31:0] m_bad = '0;

   function automatic bit f_fault(input logic [2:0] c, input logic [31:0] a);
      bit dm, dev;
      dm  = (a <= 32'h0000_2FFF);
      dev = (a >= 32'h0000_7F00) && (a <= 32'h0000_7F1B);
      if (c == SH && a % 2 != 0) return 1'b1;
      if (c == SW && a % 4 != 0) return 1'b1;
      if (!dm && !dev) return 1'b1;
      if ((c == SB || c == SH) && dev) return 1'b1;
      return 1'b0;
   endfunction

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         mq.delete();
         m_exc = 1'b0;
         m_bad = '0;
      end else begin
         bit   acc, pop;
         ent_t e;
         acc = st_valid && (mq.size() < DEPTH) && (st_ctr == SB || st_ctr == SH || st_ctr == SW);
         pop = (mq.size() > 0) && mem_ready;
         m_exc = acc && f_fault(st_ctr, st_addr);
         if (m_exc) m_bad = st_addr;
         if (pop) void'(mq.pop_front());
         if (acc && !m_exc) begin
            e.a = st_addr - (st_addr % 4);
            if (st_ctr == SW) begin
               e.be = 4'hF; e.d = st_data;
            end else if (st_ctr == SH) begin
               e.be = (st_addr % 4 >= 2) ? 4'hC : 4'h3;
               e.d  = (st_data % 32'h10000) * 32'h0001_0001;
            end else begin
               e.be = 4'(1 << (st_addr % 4));
               e.d  = (st_data % 32'h100) * 32'h0101_0101;
            end
            mq.push_back(e);
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         bit hit;
         hit = 1'b0;
         foreach (mq[i]) if (ld_en && (mq[i].a / 4 == ld_addr / 4)) hit = 1'b1;
         chk("st_ready", 32'(st_ready), 32'(mq.size() < DEPTH));
         chk("mem_we",   32'(mem_we),   32'(mq.size() != 0));
         chk("empty",    32'(empty),    32'(mq.size() == 0));
         chk("exc_ades", 32'(exc_ades), 32'(m_exc));
         chk("badvaddr", badvaddr, m_bad);
         chk("ld_hit",   32'(ld_hit),   32'(hit));
         if (mq.size() != 0) begin
            chk("mem_addr",  mem_addr,      mq[0].a);
            chk("mem_be",    32'(mem_be),   32'(mq[0].be));
            chk("mem_wdata", mem_wdata,     mq[0].d);
         end else begin
            chk("mem_be_idle",    32'(mem_be), 32'h0);
            chk("mem_wdata_idle", mem_wdata,   32'h0);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic store(input logic [2:0] c, input logic [31:0] a, input logic [31:0] d);
      st_valid = 1'b1; st_ctr = c; st_addr = a; st_data = d;
      tick();
      st_valid = 1'b0;
   endtask

   task automatic t1_check(input string tag);
      mem_ready = 1'b1;
      store(SB, 32'h0000_1003, 32'h1234_56AB);
      chk({tag, "_we"},    32'(mem_we), 32'h1);
      chk({tag, "_addr"},  mem_addr,    32'h0000_1000);
      chk({tag, "_be"},    32'(mem_be), 32'h8);
      chk({tag, "_wdata"}, mem_wdata,   32'hABAB_ABAB);
      tick();
      chk({tag, "_retired"}, 32'(mem_we), 32'h0);
   endtask

   initial begin
      #12;
      chk_en = 1'b1;
      chk("rst_empty", 32'(empty),    32'h1);
      chk("rst_we",    32'(mem_we),   32'h0);
      chk("rst_exc",   32'(exc_ades), 32'h0);
      chk("rst_bad",   badvaddr,      32'h0);
      @(posedge clk); #1 reset_n = 1'b1;
      tick();
      chk("idle_ready", 32'(st_ready), 32'h1);

      t1_check("t1");

      // Faults and the device window
      store(SH, 32'h0000_0001, 32'hFFFF_FFFF);
      chk("t2_exc", 32'(exc_ades), 32'h1);
      chk("t2_bad", badvaddr,      32'h0000_0001);
      chk("t2_we",  32'(mem_we),   32'h0);
      tick();
      chk("t2_pulse", 32'(exc_ades), 32'h0);
      chk("t2_hold",  badvaddr,      32'h0000_0001);
      store(SB, 32'h0000_7F04, 32'h1);
      chk("t2b_exc", 32'(exc_ades), 32'h1);
      store(SW, 32'h0000_3000, 32'h2);
      chk("t2c_exc", 32'(exc_ades), 32'h1);
      chk("t2c_bad", badvaddr,      32'h0000_3000);
      store(SW, 32'h0000_7F04, 32'hCAFE_F00D);
      chk("t2d_exc",  32'(exc_ades), 32'h0);
      chk("t2d_be",   32'(mem_be),   32'hF);
      chk("t2d_addr", mem_addr,      32'h0000_7F04);
      tick();
      store(SW, 32'h0000_0006, 32'h3);
      chk("sw_misalign", 32'(exc_ades), 32'h1);
      store(SH, 32'h0000_7F1A, 32'h4);
      chk("sh_dev", 32'(exc_ades), 32'h1);
      store(SB, 32'h0000_2FFF, 32'h0000_00C3);
      chk("sb_dmhi_be", 32'(mem_be), 32'h8);
      tick();
      store(3'b111, 32'h0000_0100, 32'h5);
      chk("bad_ctr_we",  32'(mem_we),   32'h0);
      chk("bad_ctr_exc", 32'(exc_ades), 32'h0);

      // Fill, back-pressure, then in-order drain
      mem_ready = 1'b0;
      for (int i = 0; i < 4; i++) store(SW, 32'(4 * i), 32'h1000_0000 + 32'(i));
      chk("t3_full", 32'(st_ready), 32'h0);
      st_valid = 1'b1; st_ctr = SW; st_addr = 32'h10; st_data = 32'h55;
      tick();
      chk("t3_held", mem_addr, 32'h0);
      mem_ready = 1'b1;
      tick();
      chk("t3_ready_back", 32'(st_ready), 32'h1);
      chk("t3_ret1",       mem_addr,      32'h4);
      tick();
      st_valid = 1'b0;
      chk("t3_ret2", mem_addr, 32'h8);
      tick();
      chk("t3_ret3", mem_addr, 32'hC);
      tick();
      chk("t3_ret4", mem_addr, 32'h10);
      tick();
      chk("t3_drained", 32'(empty), 32'h1);

      // Load hazard
      mem_ready = 1'b0;
      st_valid = 1'b1; st_ctr = SH; st_addr = 32'h30; st_data = 32'h1;
      ld_en = 1'b1; ld_addr = 32'h30;
      #1 chk("t4_same_cycle", 32'(ld_hit), 32'h0);
      tick();
      st_valid = 1'b0;
      store(SH, 32'h0000_0022, 32'h7777_BEEF);
      ld_addr = 32'h20;
      #1 chk("t4_hit", 32'(ld_hit), 32'h1);
      ld_addr = 32'h24;
      #1 chk("t4_miss", 32'(ld_hit), 32'h0);
      ld_addr = 32'h20;
      mem_ready = 1'b1;
      tick();
      chk("t4_be",    32'(mem_be), 32'hC);
      chk("t4_wdata", mem_wdata,   32'hBEEF_BEEF);
      tick();
      chk("t4_drained", 32'(ld_hit), 32'h0);
      ld_en = 1'b0;

      // Steady push/pop at count=2 across pointer wrap
      mem_ready = 1'b0;
      store(SW, 32'h200, 32'hA0A0_A0A0);
      store(SW, 32'h204, 32'hA1A1_A1A1);
      mem_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         st_valid = 1'b1; st_ctr = SW;
         st_addr = 32'h300 + 32'(4 * i); st_data = 32'h1111_1111 * 32'(i + 1);
         tick();
         chk("t5_ready", 32'(st_ready), 32'h1);
      end
      st_valid = 1'b0;
      chk("t5_head", mem_addr, 32'h320);
      tick(); tick(); tick();

      // Reset mid-drain
      mem_ready = 1'b0;
      for (int i = 0; i < 3; i++) store(SW, 32'h400 + 32'(4 * i), 32'(i));
      mem_ready = 1'b1;
      tick();
      #2 reset_n = 1'b0;
      #1;
      chk("t6_we",    32'(mem_we),   32'h0);
      chk("t6_empty", 32'(empty),    32'h1);
      chk("t6_exc",   32'(exc_ades), 32'h0);
      tick();
      reset_n = 1'b1;
      tick();
      t1_check("t6_t1");

      chk_en = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
